mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the pipeline's instruction-fetch

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W  = 64;
  localparam int MEM_DATA_W  = 64;
  localparam int MEM_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting and raises
// force_grant once the fetch port has been passed over STARVE_MAX times.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic grant_i,
  input  logic grant_d,
  output logic force_grant
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // Saturating starvation count; any fetch grant or an idle fetch port clears it
  always_ff @(posedge clk) begin
    if (rst || !if_req || grant_i) begin
      cnt <= '0;
    end else if (grant_d && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_grant = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the data port,
// one transaction at a time, and produces the pipeline stall requests.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int INSTR_W    = MEM_INSTR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_kill,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_ack,
  output logic               m_req,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic               m_ready,
  output logic               stall_if,
  output logic               stall_mem
);

  arb_state_t state, state_nxt;
  logic       kill_pend;
  logic       if_elig, d_elig;
  logic       grant_i, grant_d;
  logic       force_grant;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .grant_i     (grant_i),
    .grant_d     (grant_d),
    .force_grant (force_grant)
  );

  // Grant decision and next state; a port acked this cycle still shows its old request
  always_comb begin
    if_elig   = if_req & ~if_ack & ~if_kill;
    d_elig    = d_req & ~d_ack;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (if_elig && (!d_elig || force_grant)) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (d_elig) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory command captured at grant and held; request dropped on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (grant_i) begin
      m_req  <= 1'b1;
      m_we   <= 1'b0;
      m_addr <= if_addr;
    end else if (grant_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (m_ready && (state != IDLE)) begin
      m_req <= 1'b0;
    end
  end

  // Completion: ack pulse and read data one cycle after m_ready; killed fetches stay silent
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      kill_pend <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (state == BUSY_I) begin
        if (m_ready) begin
          kill_pend <= 1'b0;
          if (!kill_pend && !if_kill) begin
            if_ack   <= 1'b1;
            if_rdata <= m_addr[2] ? m_rdata[DATA_W-1 -: INSTR_W] : m_rdata[INSTR_W-1:0];
          end
        end else if (if_kill) begin
          kill_pend <= 1'b1;
        end
      end
      if ((state == BUSY_D) && m_ready) begin
        d_ack   <= 1'b1;
        d_rdata <= m_rdata;
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with programmable latency,
// cycle-level reference model, directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [IW-1:0] if_rdata;
  logic          if_ack, d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          stall_if, stall_mem;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int            lat = 2;
  int            mcnt = 0;
  logic [DW-1:0] mem [0:1023];
  logic [1023:0] wr_valid;

  function automatic logic [DW-1:0] dflt(input int idx);
    if (idx == 2) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {32'hD00D_0000 + idx, 32'hF00D_0000 + idx};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[12:3]);
    if (wr_valid[idx]) return mem[idx];
    return dflt(idx);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready  <= 1'b0;
      mcnt     <= 0;
      m_rdata  <= '0;
      wr_valid <= '0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
      mcnt    <= 0;
    end else if (m_req) begin
      if (mcnt + 1 >= lat) begin
        m_ready <= 1'b1;
        m_rdata <= mem_rd(m_addr);
        mcnt    <= 0;
        if (m_we) begin
          mem[m_addr[12:3]]      <= m_wdata;
          wr_valid[m_addr[12:3]] <= 1'b1;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int            owner = 0;  // 0 none, 1 fetch, 2 data
  int            scnt  = 0;
  bit            kp = 0, e_mreq = 0, e_mwe = 0, e_iack = 0, e_dack = 0;
  logic [AW-1:0] e_maddr = '0;
  logic [DW-1:0] e_mwdata = '0, e_drdata = '0;
  logic [IW-1:0] e_irdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      owner <= 0; scnt <= 0; kp <= 0; e_mreq <= 0; e_mwe <= 0; e_iack <= 0; e_dack <= 0;
      e_maddr <= '0; e_mwdata <= '0; e_drdata <= '0; e_irdata <= '0;
    end else begin
      e_iack <= 0;
      e_dack <= 0;
      if (owner == 0) begin
        if (if_req && !e_iack && !if_kill && (!(d_req && !e_dack) || scnt == SM)) begin
          owner <= 1; e_mreq <= 1; e_mwe <= 0; e_maddr <= if_addr; scnt <= 0;
        end else if (d_req && !e_dack) begin
          owner <= 2; e_mreq <= 1; e_mwe <= d_we; e_maddr <= d_addr; e_mwdata <= d_wdata;
          scnt <= if_req ? ((scnt < SM) ? scnt + 1 : SM) : 0;
        end else if (!if_req) begin
          scnt <= 0;
        end
      end else begin
        if (!if_req) scnt <= 0;
        if (m_ready) begin
          owner <= 0; e_mreq <= 0; kp <= 0;
          if (owner == 2) begin
            e_dack <= 1; e_drdata <= m_rdata;
          end else if (!kp && !if_kill) begin
            e_iack <= 1; e_irdata <= e_maddr[2] ? m_rdata[63:32] : m_rdata[31:0];
          end
        end else if (owner == 1 && if_kill) begin
          kp <= 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  logic [AW-1:0] glog[$];
  bit            prev_mreq = 0;

  always @(negedge clk) begin
    if (run) begin
      chk("m_req", m_req, e_mreq);
      chk("m_we", m_we, e_mwe);
      chk("m_addr", m_addr, e_maddr);
      chk("m_wdata", m_wdata, e_mwdata);
      chk("if_ack", if_ack, e_iack);
      chk("d_ack", d_ack, e_dack);
      chk("if_rdata", if_rdata, e_irdata);
      chk("d_rdata", d_rdata, e_drdata);
      chk("stall_if", stall_if, if_req & ~e_iack);
      chk("stall_mem", stall_mem, d_req & ~e_dack);
      if (m_req && !prev_mreq) glog.push_back(m_addr);
      prev_mreq = m_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 0; d_req = 0; if_kill = 0; d_we = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_if(input string nm, output int k);
    k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_ack) begin k = c; break; end
    end
    if (k < 0) begin
      total++; bad++;
      $display("FAIL %s: no if_ack within 40 cycles, expected one", nm);
    end
  endtask

  task automatic wait_d(input string nm, output int k);
    k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_ack) begin k = c; break; end
    end
    if (k < 0) begin
      total++; bad++;
      $display("FAIL %s: no d_ack within 40 cycles, expected one", nm);
    end
  endtask

  task automatic count_acks(input int n, output int ia, output int da);
    ia = 0; da = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (if_ack) ia++;
      if (d_ack) da++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ia, da, dcount;
    bit saw_rdy, found;

    // Reset state
    do_reset();
    run = 1'b1;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);   chk("rst_m_we", m_we, 0);
    chk("rst_if_ack", if_ack, 0); chk("rst_d_ack", d_ack, 0);
    chk("rst_m_addr", m_addr, 0); chk("rst_d_rdata", d_rdata, 0);
    step();

    // 1: fetch only, latency 2
    lat = 2;
    if_req = 1; if_addr = 64'h10;
    wait_if("t1_ack_a", k);
    chk("t1_lat_a", k, 4);
    chk("t1_data_a", if_rdata, 32'hCCCC_DDDD);
    step();
    if_addr = 64'h14;
    wait_if("t1_ack_b", k);
    chk("t1_lat_b", k, 4);
    chk("t1_data_b", if_rdata, 32'hAAAA_BBBB);
    step();
    if_req = 0;

    // 2: simultaneous fetch + load, data wins, fetch granted in the ack cycle
    do_reset();
    lat = 2; glog.delete();
    if_req = 1; if_addr = 64'h1000;
    d_req = 1; d_we = 0; d_addr = 64'h100;
    k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("t2_stall_if", stall_if, 1);
      if (d_ack) begin k = c; break; end
    end
    chk("t2_d_lat", k, 4);
    chk("t2_d_data", d_rdata, 64'hD00D_0020_F00D_0020);
    step();
    d_req = 0;
    wait_if("t2_if_ack", k);
    chk("t2_if_lat", k, 3);
    chk("t2_if_data", if_rdata, 32'hF00D_0200);
    chk("t2_ngrant", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t2_grant0", glog[0], 64'h100);
      chk("t2_grant1", glog[1], 64'h1000);
    end
    step();
    if_req = 0;

    // 3: starvation; fetch blocked in data-ack cycles so data keeps winning
    do_reset();
    lat = 1; glog.delete(); dcount = 0;
    if_req = 1; if_addr = 64'h3000;
    d_req = 1; d_we = 0; d_addr = 64'h400;
    k = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (if_ack) begin k = c; break; end
      if (d_ack) begin
        dcount++;
        if_kill = 1;
        step();
        if_kill = 0;
        d_addr = d_addr + 64'h8;
      end
    end
    if (k < 0) begin
      total++; bad++;
      $display("FAIL t3_if_ack: no if_ack within 100 cycles, expected one");
    end
    chk("t3_dgrants", dcount, 4);
    chk("t3_starve_cnt", dut.u_starve.cnt, 0);
    chk("t3_ngrant", glog.size(), 5);
    if (glog.size() >= 5) begin
      chk("t3_grant0", glog[0], 64'h400);
      chk("t3_grant3", glog[3], 64'h418);
      chk("t3_grant4", glog[4], 64'h3000);
    end
    step();
    if_req = 0;
    wait_d("t3_drain", k);
    step();
    d_req = 0;

    // 4: store held until m_ready, then read back
    do_reset();
    lat = 3;
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'h1234;
    saw_rdy = 0; k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_ack) begin
        k = c;
        chk("t4_ack_after_ready", saw_rdy, 1);
        break;
      end
      if (m_req) begin
        chk("t4_m_we", m_we, 1);
        chk("t4_m_addr", m_addr, 64'h200);
        chk("t4_m_wdata", m_wdata, 64'h1234);
      end
      saw_rdy = m_ready;
    end
    chk("t4_st_lat", k, 5);
    step();
    d_we = 0;
    wait_d("t4_ld_ack", k);
    chk("t4_ld_lat", k, 5);
    chk("t4_ld_data", d_rdata, 64'h1234);
    step();
    d_req = 0;

    // 5: kill during BUSY_I, kill on the m_ready cycle, then a normal fetch
    do_reset();
    lat = 3;
    if_req = 1; if_addr = 64'h2000;
    step(); step();
    if_kill = 1; if_req = 0;
    step();
    if_kill = 0;
    count_acks(8, ia, da);
    chk("t5_kill_mid", ia, 0);
    step();
    if_req = 1; if_addr = 64'h2008;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_ready) begin found = 1; break; end
    end
    chk("t5_saw_ready", found, 1);
    if_kill = 1;
    step();
    if_kill = 0; if_req = 0;
    count_acks(6, ia, da);
    chk("t5_kill_rdy", ia, 0);
    step();
    if_req = 1; if_addr = 64'h10;
    wait_if("t5_refetch", k);
    chk("t5_refetch_lat", k, 5);
    chk("t5_refetch_data", if_rdata, 32'hCCCC_DDDD);
    step();
    if_req = 0;

    // 6: reset in BUSY_D abandons the transaction
    do_reset();
    lat = 4;
    d_req = 1; d_we = 0; d_addr = 64'h208;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_req) begin found = 1; break; end
    end
    chk("t6_busy", found, 1);
    step();
    rst = 1;
    step();
    rst = 0; d_req = 0;
    @(negedge clk);
    chk("t6_m_req", m_req, 0);
    chk("t6_d_ack", d_ack, 0);
    count_acks(8, ia, da);
    chk("t6_no_dack", da, 0);
    step();
    d_req = 1; d_addr = 64'h10;
    wait_d("t6_fresh", k);
    chk("t6_fresh_lat", k, 6);
    chk("t6_fresh_data", d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    d_req = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
